// File: rtl/ssd_scan_capture.sv
// Scan-side monitor for a multiplexed seven-segment display. It waits for each digit strobe to
// settle, then decodes the active-low segment bus back into hex nibbles and per-digit flags.
module ssd_scan_capture #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        x1,
   input  logic        reset,
   input  logic [3:0]  anodes,
   input  logic [7:0]  SSD,
   output logic [15:0] digits,
   output logic [3:0]  dps,
   output logic [3:0]  blank,
   output logic [3:0]  bad_code,
   output logic [3:0]  digit_valid,
   output logic        frame_strobe,
   output logic        scan_err
);

   typedef enum logic [1:0] {StIdle, StSettle, StHeld, StFault} state_e;

   localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

   logic [11:0] s1_q;
   logic [11:0] s2_q;
   logic [7:0]  cnt_q;
   logic [7:0]  cnt_d;
   state_e      state_q;

   logic [15:0] digits_q;
   logic [3:0]  dps_q;
   logic [3:0]  blank_q;
   logic [3:0]  bad_q;
   logic [3:0]  valid_q;
   logic [3:0]  seen_q;
   logic        frame_q;
   logic        err_q;

   logic        changed;
   logic        cnt_hit;
   logic [6:0]  seg_hi;
   logic [5:0]  dec;
   logic [3:0]  sel;
   logic [15:0] digits_cap;
   logic [3:0]  dps_cap;
   logic [3:0]  blank_cap;
   logic [3:0]  bad_cap;
   logic [3:0]  valid_cap;
   logic [3:0]  seen_cap;

   // Returns {bad, blank, nibble} for an active-high g..a pattern.
   function automatic logic [5:0] decode_seg(input logic [6:0] seg);
      case (seg)
         7'h3F:   return {2'b00, 4'h0};
         7'h06:   return {2'b00, 4'h1};
         7'h5B:   return {2'b00, 4'h2};
         7'h4F:   return {2'b00, 4'h3};
         7'h66:   return {2'b00, 4'h4};
         7'h6D:   return {2'b00, 4'h5};
         7'h7D:   return {2'b00, 4'h6};
         7'h07:   return {2'b00, 4'h7};
         7'h7F:   return {2'b00, 4'h8};
         7'h6F:   return {2'b00, 4'h9};
         7'h77:   return {2'b00, 4'hA};
         7'h7C:   return {2'b00, 4'hB};
         7'h39:   return {2'b00, 4'hC};
         7'h5E:   return {2'b00, 4'hD};
         7'h79:   return {2'b00, 4'hE};
         7'h71:   return {2'b00, 4'hF};
         7'h00:   return {2'b01, 4'h0};
         default: return {2'b10, 4'h0};
      endcase
   endfunction

   function automatic state_e classify(input logic [3:0] an);
      case (an)
         4'b1111:                            return StIdle;
         4'b1110, 4'b1101, 4'b1011, 4'b0111: return StSettle;
         default:                            return StFault;
      endcase
   endfunction

   // s1 holds the value s2 takes at the next edge, so comparing them restarts the dwell count
   // on the same edge the new pair lands in s2.
   always_comb begin
      changed = (s1_q != s2_q);
      if (changed) begin
         cnt_d = 8'd0;
      end else if (cnt_q >= StableMax) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
      cnt_hit = !changed && (cnt_q != StableMax) && (cnt_d == StableMax);
   end

   always_comb begin
      seg_hi     = ~s2_q[6:0];
      dec        = decode_seg(seg_hi);
      sel        = ~s2_q[11:8];
      digits_cap = digits_q;
      dps_cap    = dps_q;
      blank_cap  = blank_q;
      bad_cap    = bad_q;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) begin
            digits_cap[4*i +: 4] = dec[3:0];
            dps_cap[i]           = ~s2_q[7];
            blank_cap[i]         = dec[4];
            bad_cap[i]           = dec[5];
         end
      end
      valid_cap = valid_q | sel;
      seen_cap  = seen_q | sel;
   end

   always_ff @(posedge x1) begin
      if (reset) begin
         s1_q     <= 12'hFFF;
         s2_q     <= 12'hFFF;
         cnt_q    <= 8'd0;
         state_q  <= StIdle;
         digits_q <= 16'h0000;
         dps_q    <= 4'h0;
         blank_q  <= 4'h0;
         bad_q    <= 4'h0;
         valid_q  <= 4'h0;
         seen_q   <= 4'h0;
         frame_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         s1_q    <= {anodes, SSD};
         s2_q    <= s1_q;
         cnt_q   <= cnt_d;
         frame_q <= 1'b0;
         if (changed) begin
            state_q <= classify(s1_q[11:8]);
         end else begin
            case (state_q)
               StSettle: begin
                  if (cnt_hit) begin
                     state_q  <= StHeld;
                     digits_q <= digits_cap;
                     dps_q    <= dps_cap;
                     blank_q  <= blank_cap;
                     bad_q    <= bad_cap;
                     valid_q  <= valid_cap;
                     if (seen_cap == 4'hF) begin
                        frame_q <= 1'b1;
                        seen_q  <= 4'h0;
                     end else begin
                        seen_q <= seen_cap;
                     end
                  end
               end
               StFault: begin
                  if (cnt_hit) begin
                     err_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign digits       = digits_q;
   assign dps          = dps_q;
   assign blank        = blank_q;
   assign bad_code     = bad_q;
   assign digit_valid  = valid_q;
   assign frame_strobe = frame_q;
   assign scan_err     = err_q;

endmodule

// File: tb/tb_ssd_scan_capture.sv
// Bench for ssd_scan_capture: directed scan scenarios plus random dwells, checked every cycle
// against a run-length reference model of the capture rules.
module tb_ssd_scan_capture;

   localparam int unsigned STABLE = 4;

   logic        x1 = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  anodes = 4'hF;
   logic [7:0]  SSD = 8'hFF;
   logic [15:0] digits;
   logic [3:0]  dps;
   logic [3:0]  blank;
   logic [3:0]  bad_code;
   logic [3:0]  digit_valid;
   logic        frame_strobe;
   logic        scan_err;

   int checks = 0;
   int errors = 0;
   int frames = 0;
   int frames_base;
   logic chk_en = 1'b0;

   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic [15:0] m_digits;
   logic [3:0]  m_dps;
   logic [3:0]  m_blank;
   logic [3:0]  m_bad;
   logic [3:0]  m_valid;
   logic [3:0]  m_seen;
   logic        m_frame;
   logic        m_err;
   logic [11:0] prev_in;
   logic [11:0] pend_val;
   logic [11:0] cur;
   logic        pend;
   int          run;

   ssd_scan_capture #(
      .STABLE_CYCLES(STABLE)
   ) dut (
      .x1          (x1),
      .reset       (reset),
      .anodes      (anodes),
      .SSD         (SSD),
      .digits      (digits),
      .dps         (dps),
      .blank       (blank),
      .bad_code    (bad_code),
      .digit_valid (digit_valid),
      .frame_strobe(frame_strobe),
      .scan_err    (scan_err)
   );

   always #5 x1 = ~x1;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Apply one captured pair to the model: a lone low anode decodes, several low is a fault.
   task model_capture(input logic [11:0] v);
      int         nlow;
      int         idx;
      logic [6:0] seg;
      logic [3:0] nib;
      logic       hit;
      nlow = 0;
      idx  = 0;
      for (int i = 0; i < 4; i++) begin
         if (!v[8+i]) begin
            nlow++;
            idx = i;
         end
      end
      if (nlow == 1) begin
         seg = ~v[6:0];
         nib = 4'h0;
         hit = 1'b0;
         for (int j = 0; j < 16; j++) begin
            if (hex_tab[j] == seg) begin
               nib = 4'(j);
               hit = 1'b1;
            end
         end
         m_digits[4*idx +: 4] = hit ? nib : 4'h0;
         m_blank[idx] = (seg == 7'h00);
         m_bad[idx]   = !hit && (seg != 7'h00);
         m_dps[idx]   = ~v[7];
         m_valid[idx] = 1'b1;
         m_seen[idx]  = 1'b1;
         if (m_seen == 4'hF) begin
            m_frame = 1'b1;
            m_seen  = 4'h0;
         end
      end else if (nlow > 1) begin
         m_err = 1'b1;
      end
   endtask

   // A pair sampled unchanged at STABLE+1 consecutive edges is captured one edge later.
   always @(posedge x1) begin
      if (reset) begin
         m_digits = 16'h0;
         m_dps    = 4'h0;
         m_blank  = 4'h0;
         m_bad    = 4'h0;
         m_valid  = 4'h0;
         m_seen   = 4'h0;
         m_frame  = 1'b0;
         m_err    = 1'b0;
         prev_in  = 12'hFFF;
         pend_val = 12'hFFF;
         pend     = 1'b0;
         run      = 1000;
         chk_en   = 1'b1;
      end else begin
         m_frame = 1'b0;
         if (pend) model_capture(pend_val);
         cur = {anodes, SSD};
         if (cur == prev_in) begin
            if (run < 1000) run++;
         end else begin
            run = 1;
         end
         prev_in  = cur;
         pend     = (run == int'(STABLE) + 1);
         pend_val = cur;
      end
   end

   always @(negedge x1) begin
      if (chk_en) begin
         check("digits", digits, m_digits);
         check("dps", 16'(dps), 16'(m_dps));
         check("blank", 16'(blank), 16'(m_blank));
         check("bad_code", 16'(bad_code), 16'(m_bad));
         check("digit_valid", 16'(digit_valid), 16'(m_valid));
         check("frame_strobe", 16'(frame_strobe), 16'(m_frame));
         check("scan_err", 16'(scan_err), 16'(m_err));
         if (frame_strobe) frames++;
      end
   end

   task automatic drive(input logic [3:0] an, input logic [7:0] sg, input int n);
      anodes = an;
      SSD    = sg;
      repeat (n) @(posedge x1);
      #1;
   endtask

   initial begin
      logic [3:0] an;
      logic [7:0] sg;
      int         r;

      reset = 1'b1;
      repeat (2) @(posedge x1);
      #1;
      reset = 1'b0;

      // One full frame showing 4 3 2 1.
      drive(4'b1110, ~8'h06, 20);
      drive(4'b1101, ~8'h5B, 20);
      drive(4'b1011, ~8'h4F, 20);
      drive(4'b0111, ~8'h66, 5);
      check("frame_early", 16'(frame_strobe), 16'd0);
      drive(4'b0111, ~8'h66, 1);
      check("frame_lat", 16'(frame_strobe), 16'd1);
      drive(4'b0111, ~8'h66, 14);
      check("frame_digits", digits, 16'h4321);
      check("frame_valid", 16'(digit_valid), 16'hF);

      // Blank digit, dp-lit eight, undecodable pattern.
      drive(4'b1011, 8'hFF, 10);
      drive(4'b1101, ~(8'h80 | 8'h7F), 10);
      check("blank2", 16'(blank[2]), 16'd1);
      check("blank2_nib", 16'(digits[11:8]), 16'd0);
      check("eight_nib", 16'(digits[7:4]), 16'd8);
      check("eight_dp", 16'(dps[1]), 16'd1);
      drive(4'b1110, ~8'h49, 10);
      check("bad0", 16'(bad_code[0]), 16'd1);
      check("bad0_nib", 16'(digits[3:0]), 16'd0);

      // Short glitch on digit 1 must not capture.
      drive(4'b1110, ~8'h3F, 10);
      drive(4'b1101, ~8'h6D, 3);
      drive(4'b1110, ~8'h3F, 10);
      check("glitch_d1", 16'(digits[7:4]), 16'd8);

      // Two anodes low: sticky error, data untouched.
      drive(4'b1100, ~8'h06, 10);
      check("fault_err", 16'(scan_err), 16'd1);
      drive(4'hF, 8'hFF, 10);
      check("err_sticky", 16'(scan_err), 16'd1);

      // Reset mid-frame discards the partial frame.
      reset = 1'b1;
      drive(4'hF, 8'hFF, 1);
      reset = 1'b0;
      check("reset_err", 16'(scan_err), 16'd0);
      frames_base = frames;
      drive(4'b1110, ~8'h06, 20);
      drive(4'b1101, ~8'h5B, 20);
      drive(4'b1011, ~8'h4F, 20);
      reset = 1'b1;
      drive(4'b0111, ~8'h66, 1);
      reset = 1'b0;
      drive(4'b0111, ~8'h66, 20);
      check("rst_valid", 16'(digit_valid), 16'b1000);
      check("rst_no_frame", 16'(frames - frames_base), 16'd0);

      // Random dwells, including glitches, blanks, bad codes and the odd fault.
      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 99);
         if (r < 75) begin
            an = 4'b0001 << $urandom_range(0, 3);
            an = ~an;
         end else if (r < 90) begin
            an = 4'hF;
         end else begin
            an = 4'($urandom);
         end
         r = $urandom_range(0, 9);
         if (r < 7) begin
            sg = {1'($urandom), hex_tab[$urandom_range(0, 15)]};
            sg = ~sg;
         end else if (r < 8) begin
            sg = {1'($urandom), 7'h7F};
         end else begin
            sg = 8'($urandom);
         end
         drive(an, sg, int'($urandom_range(1, 12)));
      end
      drive(4'hF, 8'hFF, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
